serial_capture: RTL and testbench
=================================

# serial_capture

Receive-side companion to the logic processor's shift controller. It samples a serial bit stream one bit per cycle while the controller's `Shift_En` is high, assembles an N-bit word LSB-first, and presents it in parallel with a `Valid` level. It detects bursts that are too short or too long, then holds until the operator releases `Execute`. It sits between the shift-register output bit and the display/compare logic.

## Interface
- `N`, default 8: word width; also the exact `Shift_En` burst length expected.
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-high; clock `Clk`.
- `Clear`  in  1  synchronous clear of flags, `Data` and FSM.
- `Execute`  in  1  operator execute level, same signal the shift controller sees.
- `Shift_En`  in  1  shift strobe from the shift controller; one bit per high cycle.
- `Shift_In`  in  1  serial data bit, valid whenever `Shift_En` is high.
- `Data`  out  N  last successfully captured word.
- `Valid`  out  1  high while a good word is presented for the current Execute.
- `Err_Short`  out  1  sticky: a burst ended with fewer than N bits.
- `Err_Long`  out  1  sticky: a burst exceeded N bits.
- `Bit_Count`  out  $clog2(N+1)  bits shifted in the current or last burst.

## Operation
- Internal shift register `sreg[N-1:0]` plus bit counter. A sampled bit enters at the MSB: `sreg <= {Shift_In, sreg[N-1:1]}`. After N shifts, the first bit received sits at bit 0.
- **States:** IDLE, CAPTURE, DONE.
- **IDLE**
  - `Valid` is 0.
  - If `Shift_En`=1: shift `Shift_In` in, `Bit_Count`<=1, go to CAPTURE.
  - Otherwise stay.
  - `Execute` is not examined.
- **CAPTURE**
  - `Shift_En`=1 and `Bit_Count`<N: shift, `Bit_Count`++.
  - `Shift_En`=1 and `Bit_Count`==N: set `Err_Long`, go to DONE. `Data` and `Valid` are unchanged (`Valid` stays 0).
  - `Shift_En`=0 and `Bit_Count`==N: `Data`<=sreg, `Valid`<=1, go to DONE.
  - `Shift_En`=0 and `Bit_Count`<N: set `Err_Short`, go to DONE. `Data` is unchanged.
  - `Execute` is ignored in this state.
- **DONE**
  - `Shift_En`/`Shift_In` are ignored; `Bit_Count` holds.
  - When `Execute`=0: `Valid`<=0, go to IDLE.
- `Err_Short` and `Err_Long` are sticky across operations. They are cleared only by `Clear` or `Reset`.
- `Clear`=1, highest synchronous priority:
  - `Data`, `Valid`, both error flags, `Bit_Count` and sreg go to 0.
  - State goes to IDLE.
  - The bit sampled in that cycle is discarded.
- `Bit_Count` saturates at N; it never wraps.
- **Reset mid-burst:** all outputs and sreg go to 0 and the state to IDLE, immediately. A burst continuing after `Reset` deasserts starts a fresh capture, counted from 1.

## Timing
- **Reset values:** `Data`=0, `Valid`=0, `Err_Short`=0, `Err_Long`=0, `Bit_Count`=0, state IDLE.
- `Shift_En`/`Shift_In` are sampled on the rising `Clk` edge. Combinational paths from inputs to outputs are forbidden; all outputs are registered.
- **Nominal burst:** `Shift_En` is high for edges 1..N and low at edge N+1. `Data`/`Valid` update at edge N+1, one cycle after the last shifted bit.
- **Release:** `Valid` falls on the first edge that samples `Execute`=0 in DONE.
- **Back-to-back bursts:** a burst may start on the same edge that DONE returns to IDLE only if `Execute`=0 and `Shift_En`=1 are both sampled there. In that case IDLE is bypassed: the bit is shifted in and the state goes directly to CAPTURE.
- **Error timing:** `Err_Long` asserts at edge N+1 of a burst with `Shift_En` still high. `Err_Short` asserts at the first low edge when fewer than N bits were received.

## Test plan
1. **Nominal capture.** N=8. Hold `Execute`=1. Drive 8 cycles of `Shift_En`=1 with `Shift_In` = 1,0,1,0,0,1,0,1, then `Shift_En`=0. Expect `Data`=0xA5 and `Valid`=1 one edge after the last bit, `Bit_Count`=8, no errors. Drop `Execute` and expect `Valid`=0 on the next edge.
2. **Short burst.** Drive only 5 shift cycles after capture 1. Expect `Err_Short`=1, `Data` still 0xA5, `Valid`=0, `Bit_Count`=5.
3. **Long burst.** Drive 10 shift cycles. Expect `Err_Long`=1 at the 9th shift edge, `Bit_Count`=8, `Data` unchanged, `Valid`=0. The extra bits must have no effect.
4. **Sticky flags and Clear.** After 2 and 3, run a nominal 0x3C capture. Expect `Data`=0x3C, `Valid`=1, and both error flags still 1. Pulse `Clear` and expect all outputs 0 and state IDLE.
5. **Async reset mid-burst.** Assert `Reset` between edges after 4 bits. Expect all outputs 0 immediately. Release `Reset` and run a full 8-bit burst of 0xFF; expect `Data`=0xFF and `Valid`=1.
6. **Execute held.** Complete a capture, keep `Execute`=1, and drive another 8-bit burst. Expect it ignored, with `Data` and `Valid` unchanged, until `Execute` falls.

Source files
------------

// File: rtl/serial_capture.sv
// Receive-side serial word capture: assembles an N-bit word LSB-first while Shift_En is high.
// It flags bursts that are too short or too long, then holds the result until Execute is released.
module serial_capture #(
    parameter int N = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     Execute,
    input  logic                     Shift_En,
    input  logic                     Shift_In,
    output logic [N-1:0]             Data,
    output logic                     Valid,
    output logic                     Err_Short,
    output logic                     Err_Long,
    output logic [$clog2(N+1)-1:0]   Bit_Count
);

    // state   | meaning
    // IDLE    | waiting for the first Shift_En of a burst
    // CAPTURE | shifting bits in, counting toward N
    // DONE    | result presented; waiting for Execute to drop
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t         state_q, state_d;
    logic [N-1:0]   sreg_q, sreg_d;
    logic [N-1:0]   data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           err_short_q, err_short_d;
    logic           err_long_q, err_long_d;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;

        if (Clear) begin
            state_d     = IDLE;
            sreg_d      = '0;
            data_d      = '0;
            cnt_d       = '0;
            valid_d     = 1'b0;
            err_short_d = 1'b0;
            err_long_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Shift_En) begin
                        sreg_d  = {Shift_In, sreg_q[N-1:1]};
                        cnt_d   = CNT_ONE;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (Shift_En) begin
                        if (cnt_q < CNT_MAX) begin
                            sreg_d = {Shift_In, sreg_q[N-1:1]};
                            cnt_d  = cnt_q + CNT_ONE;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = DONE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        data_d  = sreg_q;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_short_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    // Releasing Execute with Shift_En already high starts the next burst directly.
                    if (!Execute) begin
                        valid_d = 1'b0;
                        if (Shift_En) begin
                            sreg_d  = {Shift_In, sreg_q[N-1:1]};
                            cnt_d   = CNT_ONE;
                            state_d = CAPTURE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign Data      = data_q;
    assign Valid     = valid_q;
    assign Err_Short = err_short_q;
    assign Err_Long  = err_long_q;
    assign Bit_Count = cnt_q;

endmodule

// File: tb/tb_serial_capture.sv
// Bench for serial_capture: a queue-based reference model is checked every cycle, with directed and random bursts.
module tb_serial_capture;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Clear = 1'b0;
    logic          Execute = 1'b0;
    logic          Shift_En = 1'b0;
    logic          Shift_In = 1'b0;
    logic [N-1:0]  Data;
    logic          Valid;
    logic          Err_Short;
    logic          Err_Long;
    logic [CW-1:0] Bit_Count;

    int tests = 0;
    int fails = 0;

    serial_capture #(.N(N)) dut (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Execute(Execute),
        .Shift_En(Shift_En), .Shift_In(Shift_In), .Data(Data), .Valid(Valid),
        .Err_Short(Err_Short), .Err_Long(Err_Long), .Bit_Count(Bit_Count)
    );

    always #5 Clk = ~Clk;

    // Reference model: phase 0 waiting, 1 receiving, 2 holding the result
    int   m_phase = 0;
    bit   m_bits[$];
    int   m_cnt = 0;
    int   m_data = 0;
    bit   m_valid = 0;
    bit   m_es = 0;
    bit   m_el = 0;

    function automatic int word_of_bits();
        int w = 0;
        foreach (m_bits[i]) w += int'(m_bits[i]) << i;
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_bits = {}; m_cnt = 0; m_data = 0;
        m_valid = 0; m_es = 0; m_el = 0;
    endtask

    task automatic model_start(input bit b);
        m_bits = {}; m_bits.push_back(b); m_cnt = 1; m_phase = 1;
    endtask

    task automatic model_step(input bit clr, input bit ex, input bit se, input bit si);
        if (clr) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (se) model_start(si);
        end else if (m_phase == 1) begin
            if (se && m_cnt < N) begin
                m_bits.push_back(si); m_cnt++;
            end else if (se) begin
                m_el = 1; m_phase = 2;
            end else if (m_cnt == N) begin
                m_data = word_of_bits(); m_valid = 1; m_phase = 2;
            end else begin
                m_es = 1; m_phase = 2;
            end
        end else if (!ex) begin
            m_valid = 0;
            if (se) model_start(si);
            else    m_phase = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) model_reset();
            else       model_step(Clear, Execute, Shift_En, Shift_In);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                check("model_data",      int'(Data),      m_data);
                check("model_valid",     int'(Valid),     int'(m_valid));
                check("model_err_short", int'(Err_Short), int'(m_es));
                check("model_err_long",  int'(Err_Long),  int'(m_el));
                check("model_bit_count", int'(Bit_Count), m_cnt);
            end
        end
    end

    // Apply inputs now, let one rising edge pass, return at the following falling edge.
    task automatic cyc(input bit se, input bit si, input bit ex, input bit clr);
        Shift_En = se; Shift_In = si; Execute = ex; Clear = clr;
        @(negedge Clk);
    endtask

    task automatic burst(input int len, input logic [31:0] bits, input bit ex);
        for (int i = 0; i < len; i++) cyc(1'b1, bits[i % 32], ex, 1'b0);
        cyc(1'b0, 1'b0, ex, 1'b0);
    endtask

    task automatic pin(input string name, input int ed, input int ev, input int es, input int el, input int ec);
        check({name, "_data"},  int'(Data),      ed);
        check({name, "_valid"}, int'(Valid),     ev);
        check({name, "_eshort"}, int'(Err_Short), es);
        check({name, "_elong"}, int'(Err_Long),  el);
        check({name, "_count"}, int'(Bit_Count), ec);
    endtask

    initial begin
        #1;
        pin("reset", 0, 0, 0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // 1: nominal 0xA5 (bits arrive LSB first)
        burst(8, 32'h0000_00A5, 1'b1);
        pin("nominal", 'hA5, 1, 0, 0, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("release_valid", int'(Valid), 0);

        // 2: short burst
        burst(5, 32'h0000_001F, 1'b1);
        pin("short", 'hA5, 0, 1, 0, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 3: long burst held in DONE by Execute so the extra bit is ignored
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("long_flag_9th", int'(Err_Long), 1);
        check("long_count_9th", int'(Bit_Count), 8);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        pin("long", 'hA5, 0, 1, 1, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 4: sticky flags survive a good capture, Clear wipes everything
        burst(8, 32'h0000_003C, 1'b1);
        pin("sticky", 'h3C, 1, 1, 1, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        pin("clear", 0, 0, 0, 0, 0);
        Clear = 1'b0;

        // 5: async reset mid-burst, then fresh 0xFF
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("pre_reset_count", int'(Bit_Count), 4);
        #2 Reset = 1'b1;
        #1 pin("async_reset", 0, 0, 0, 0, 0);
        #1 Reset = 1'b0;
        burst(8, 32'h0000_00FF, 1'b1);
        pin("after_reset", 'hFF, 1, 0, 0, 8);

        // 6: Execute held, second burst ignored
        burst(8, 32'h0000_0012, 1'b1);
        pin("exec_held", 'hFF, 1, 0, 0, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("exec_release", int'(Valid), 0);

        // back-to-back: burst starts on the same edge DONE is released
        burst(8, 32'h0000_0081, 1'b0);
        check("b2b_first_valid", int'(Valid), 1);
        burst(8, 32'h0000_0066, 1'b0);
        check("b2b_second_data", int'(Data), 'h66);

        // randomized operation
        for (int op = 0; op < 400; op++) begin
            int len;
            int gap;
            int r;
            r = $urandom_range(0, 9);
            len = (r < 6) ? N : $urandom_range(1, N + 3);
            for (int i = 0; i < len; i++)
                cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));
            gap = $urandom_range(0, 3);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
            for (int g = 0; g < gap; g++)
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
